// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer for a 16-bit ISA.
module control_unit #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     Instr,
    input  logic            Zero,
    output logic [PC_W-1:0] PC,
    output logic [2:0]      AddrR1,
    output logic [2:0]      AddrR2,
    output logic [2:0]      AddrW,
    output logic            W_R,
    output logic [2:0]      AluOp,
    output logic            SelImm,
    output logic [7:0]      Imm,
    output logic            Halt,
    output logic            Err
);
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
    state_t state, nextState;
    logic [15:0] ir;
    logic        taken, errReg;
    logic [3:0]  op;
    logic        illegal, writes, jump, active;
    assign op      = ir[15:12];
    assign illegal = op >= 4'd10 && op <= 4'd14;
    assign writes  = op >= 4'd1 && op <= 4'd7;
    assign jump    = op == 4'd8 || (op == 4'd9 && taken);
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            PC     <= '0;
            ir     <= '0;
            taken  <= 1'b0;
            errReg <= 1'b0;
        end else begin
            state <= nextState;
            if (state == FETCH) ir <= Instr;
            if (state == DECODE && illegal) errReg <= 1'b1;
            if (state == EXECUTE) taken <= op == 4'd9 && Zero;
            if (state == WRITEBACK) PC <= jump ? PC_W'(ir[7:0]) : PC + PC_W'(1);
        end
    end
    always_comb begin
        nextState = state == FETCH     ? DECODE :
                    state == DECODE    ? (op == 4'hF ? HALT : EXECUTE) :
                    state == EXECUTE   ? WRITEBACK :
                    state == WRITEBACK ? FETCH : HALT;
    end
    always_comb begin
        active = state == DECODE || state == EXECUTE || state == WRITEBACK;
        AddrR1 = active ? ir[8:6] : 3'd0;
        AddrR2 = active ? ir[5:3] : 3'd0;
        W_R    = state == WRITEBACK && writes;
        AddrW  = W_R ? ir[11:9] : 3'd0;
        SelImm = state == WRITEBACK && op == 4'd6;
        AluOp  = op == 4'd1 ? 3'b000 :
                 op == 4'd2 ? 3'b001 :
                 op == 4'd3 ? 3'b010 :
                 op == 4'd4 ? 3'b011 :
                 op == 4'd5 ? 3'b100 :
                 op == 4'd7 ? 3'b101 :
                 op == 4'd6 ? 3'b110 : 3'b000;
        Imm    = ir[7:0];
        Halt   = state == HALT;
        // The flag shows already in DECODE; the register keeps it afterwards.
        Err    = errReg || (state == DECODE && illegal);
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: vector table and scoreboard for control_unit, plus halt/reset sequences.
module tb_control_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] Instr;
    logic        Zero = 1'b0;
    logic [7:0]  PC;
    logic [2:0]  AddrR1, AddrR2, AddrW, AluOp;
    logic        W_R, SelImm, Halt, Err;
    logic [7:0]  Imm;
    logic [15:0] mem [256];
    int          total = 0;
    int          passed = 0;

    typedef struct {
        logic [15:0] instr;
        logic        zero;
        logic        wr;
        logic        sel;
        logic [2:0]  alu;
        logic [7:0]  pc;
        logic        err;
    } vec_t;

    vec_t vecs [14];
    vec_t sb [$];

    control_unit #(.PC_W(8)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .PC(PC),
        .AddrR1(AddrR1), .AddrR2(AddrR2), .AddrW(AddrW), .W_R(W_R), .AluOp(AluOp),
        .SelImm(SelImm), .Imm(Imm), .Halt(Halt), .Err(Err)
    );

    assign Instr = mem[PC];
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic runInstr(input vec_t v, input logic [7:0] at);
        vec_t e;
        mem[at] = v.instr;
        Zero = v.zero;
        sb.push_back(v);
        chk("fetch_r1", AddrR1, 0);
        tick();
        chk("dec_r1", AddrR1, v.instr[8:6]);
        chk("dec_r2", AddrR2, v.instr[5:3]);
        chk("dec_wr", W_R, 0);
        chk("dec_err", Err, v.err);
        tick();
        chk("exe_wr", W_R, 0);
        tick();
        e = sb.pop_front();
        chk("wb_wr", W_R, e.wr);
        chk("wb_addrw", AddrW, e.wr ? e.instr[11:9] : 3'd0);
        chk("wb_sel", SelImm, e.sel);
        chk("wb_alu", AluOp, e.alu);
        chk("wb_imm", Imm, e.instr[7:0]);
        chk("wb_r1", AddrR1, e.instr[8:6]);
        tick();
        chk("next_pc", PC, e.pc);
        chk("err_after", Err, e.err);
    endtask

    initial begin
        logic [7:0] mPc;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        //           instr      zero  wr    sel   alu     pc     err
        vecs[0]  = '{16'h665A, 1'b0, 1'b1, 1'b1, 3'b110, 8'h01, 1'b0};
        vecs[1]  = '{16'h1298, 1'b0, 1'b1, 1'b0, 3'b000, 8'h02, 1'b0};
        vecs[2]  = '{16'h2BB8, 1'b0, 1'b1, 1'b0, 3'b001, 8'h03, 1'b0};
        vecs[3]  = '{16'h3440, 1'b0, 1'b1, 1'b0, 3'b010, 8'h04, 1'b0};
        vecs[4]  = '{16'h4E00, 1'b0, 1'b1, 1'b0, 3'b011, 8'h05, 1'b0};
        vecs[5]  = '{16'h5050, 1'b0, 1'b1, 1'b0, 3'b100, 8'h06, 1'b0};
        vecs[6]  = '{16'h7940, 1'b0, 1'b1, 1'b0, 3'b101, 8'h07, 1'b0};
        vecs[7]  = '{16'h9120, 1'b1, 1'b0, 1'b0, 3'b000, 8'h20, 1'b0};
        vecs[8]  = '{16'h9120, 1'b0, 1'b0, 1'b0, 3'b000, 8'h21, 1'b0};
        vecs[9]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 8'h22, 1'b0};
        vecs[10] = '{16'hC000, 1'b0, 1'b0, 1'b0, 3'b000, 8'h23, 1'b1};
        vecs[11] = '{16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 8'h24, 1'b1};
        vecs[12] = '{16'h80FF, 1'b0, 1'b0, 1'b0, 3'b000, 8'hFF, 1'b1};
        vecs[13] = '{16'h0000, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b1};

        doReset();
        chk("rst_pc", PC, 0);
        chk("rst_wr", W_R, 0);
        chk("rst_sel", SelImm, 0);
        chk("rst_halt", Halt, 0);
        chk("rst_err", Err, 0);
        chk("rst_alu", AluOp, 0);
        chk("rst_r1", AddrR1, 0);
        chk("rst_r2", AddrR2, 0);
        chk("rst_w", AddrW, 0);

        mPc = 8'h00;
        for (int i = 0; i < 14; i++) begin
            runInstr(vecs[i], mPc);
            mPc = vecs[i].pc;
        end

        doReset();
        chk("err_cleared", Err, 0);
        chk("pc_cleared", PC, 0);

        mem[0] = 16'hF000;
        tick();
        chk("halt_dec", Halt, 0);
        tick();
        chk("halt_on", Halt, 1);
        for (int i = 0; i < 10; i++) begin
            chk("halt_hold", Halt, 1);
            chk("halt_pc", PC, 0);
            chk("halt_wr", W_R, 0);
            chk("halt_r1", AddrR1, 0);
            tick();
        end

        doReset();
        chk("unhalt", Halt, 0);
        mem[0] = 16'h1298;
        tick();
        tick();
        tick();
        chk("pre_rst_wr", W_R, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_wr", W_R, 0);
        chk("mid_rst_pc", PC, 0);
        chk("mid_rst_r1", AddrR1, 0);
        chk("mid_rst_w", AddrW, 0);
        tick();
        chk("restart_dec_r1", AddrR1, 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
